// File: rtl/dac_sample_scheduler.sv
// Paced DAC sample scheduler: two valid/ready requesters share one FIFO through a
// round-robin arbiter, and a programmable tick pops one sample onto the held DAC code.
module dac_sample_scheduler #(
  parameter int               WIDTH      = 10,
  parameter int               DEPTH      = 8,
  parameter int               DIV_W      = 16,
  parameter logic [WIDTH-1:0] RESET_CODE = '0
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       en,
  input  logic [DIV_W-1:0]           div,
  input  logic [WIDTH-1:0]           req0_data,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [WIDTH-1:0]           req1_data,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  output logic [WIDTH-1:0]           D,
  output logic                       update,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       underrun,
  input  logic                       clr_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             update_q, update_d;
  logic             underrun_q, underrun_d;
  logic             last_grant_q, last_grant_d;

  logic             full_s, empty_s, tick_s, pop_s;
  logic             push0_s, push1_s, push_s;
  logic [WIDTH-1:0] push_data_s;

  // Arbitration, pacing and next-state logic, all from registered state
  always_comb begin
    full_s  = (level_q == LW'(DEPTH));
    empty_s = (level_q == {LW{1'b0}});

    // Contention goes to the requester that did not win the last push
    req0_ready = !full_s && (!req1_valid || last_grant_q);
    req1_ready = !full_s && (!req0_valid || !last_grant_q);

    push0_s     = req0_valid && req0_ready;
    push1_s     = req1_valid && req1_ready;
    push_s      = push0_s || push1_s;
    push_data_s = push1_s ? req1_data : req0_data;

    tick_s = en && (cnt_q >= div);
    pop_s  = tick_s && !empty_s;

    if (!en) begin
      cnt_d = {DIV_W{1'b0}};
    end else if (tick_s) begin
      cnt_d = {DIV_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end

    wr_ptr_d = push_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + {{(LW-1){1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{(LW-1){1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase

    d_d      = pop_s ? mem_q[rd_ptr_q] : d_q;
    update_d = pop_s;

    // An underrun in the same cycle as a clear keeps the flag set
    if (tick_s && empty_s) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end

    if (push0_s) begin
      last_grant_d = 1'b0;
    end else if (push1_s) begin
      last_grant_d = 1'b1;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Control state register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      level_q      <= {LW{1'b0}};
      cnt_q        <= {DIV_W{1'b0}};
      d_q          <= RESET_CODE;
      update_q     <= 1'b0;
      underrun_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      update_q     <= update_d;
      underrun_q   <= underrun_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Sample storage; contents are dead once the pointers are reset
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

  assign D          = d_q;
  assign update     = update_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_dac_sample_scheduler;

  logic       CLK = 1'b0;
  logic       reset;
  logic       en;
  logic [15:0] div;
  logic [9:0] req0_data, req1_data;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [9:0] D;
  logic       update;
  logic [3:0] fifo_level;
  logic       underrun;
  logic       clr_underrun;

  int total = 0;
  int bad   = 0;

  dac_sample_scheduler dut (
    .CLK(CLK), .reset(reset), .en(en), .div(div),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .D(D), .update(update), .fifo_level(fifo_level),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    int ups;
    reset = 1'b1; en = 1'b0; div = 16'd3; clr_underrun = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 10'h000; req1_data = 10'h000;
    #3;
    total++; if (D !== 10'h000) begin bad++; $display("FAIL reset_D got=%h exp=%h", D, 10'h000); end
    total++; if (update !== 1'b0) begin bad++; $display("FAIL reset_update got=%b exp=0", update); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    cyc();
    reset = 1'b0;
    ups = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (update === 1'b1) ups++;
    end
    total++; if (ups !== 0) begin bad++; $display("FAIL idle_updates got=%0d exp=0", ups); end
    total++; if (D !== 10'h000) begin bad++; $display("FAIL idle_D got=%h exp=%h", D, 10'h000); end
  endtask

  task automatic test_pacing();
    logic [9:0] vals [3];
    int n;
    vals[0] = 10'h155; vals[1] = 10'h2AA; vals[2] = 10'h3FF;
    en = 1'b1; div = 16'd3;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_data = vals[i];
      #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL pace_ready%0d got=%b exp=1", i, req0_ready); end
      cyc();
    end
    req0_valid = 1'b0;
    total++; if (fifo_level !== 4'd3) begin bad++; $display("FAIL pace_level got=%0d exp=3", fifo_level); end
    n = 0;
    for (int c = 3; c <= 16; c++) begin
      cyc();
      if (c == 14) begin
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL pace_early_underrun got=%b exp=0", underrun); end
      end
      if (update === 1'b1) begin
        total++;
        if (n >= 3) begin
          bad++; $display("FAIL pace_extra_update got=%0d exp=3", n + 1);
        end else if (c != 3 + 4 * n || D !== vals[n]) begin
          bad++; $display("FAIL pace_update%0d got=cyc%0d/%h exp=cyc%0d/%h", n, c, D, 3 + 4 * n, vals[n]);
        end
        n++;
      end
    end
    total++; if (n !== 3) begin bad++; $display("FAIL pace_count got=%0d exp=3", n); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL pace_underrun got=%b exp=1", underrun); end
    total++; if (D !== 10'h3FF) begin bad++; $display("FAIL pace_hold_D got=%h exp=%h", D, 10'h3FF); end
    en = 1'b0; clr_underrun = 1'b1;
    cyc();
    clr_underrun = 1'b0;
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL pace_clr got=%b exp=0", underrun); end
  endtask

  task automatic test_no_bypass();
    en = 1'b1; div = 16'd0;
    req0_valid = 1'b1; req0_data = 10'h0AB;
    cyc();
    req0_valid = 1'b0;
    total++; if (update !== 1'b0) begin bad++; $display("FAIL bypass_update got=%b exp=0", update); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL bypass_underrun got=%b exp=1", underrun); end
    total++; if (D !== 10'h3FF) begin bad++; $display("FAIL bypass_D_hold got=%h exp=%h", D, 10'h3FF); end
    cyc();
    total++; if (update !== 1'b1 || D !== 10'h0AB) begin bad++; $display("FAIL bypass_pop got=%b/%h exp=1/%h", update, D, 10'h0AB); end
    en = 1'b0; clr_underrun = 1'b1;
    cyc();
    clr_underrun = 1'b0;
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL bypass_clr got=%b exp=0", underrun); end
  endtask

  task automatic test_contention();
    int n0, n1;
    logic e0, e1;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    en = 1'b0; n0 = 0; n1 = 0;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 10'h001 + 10'(n0);
      req1_data = 10'h101 + 10'(n1);
      #1;
      e0 = (i < 8) && (i % 2 == 0);
      e1 = (i < 8) && (i % 2 == 1);
      total++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        bad++; $display("FAIL cont_ready%0d got=%b%b exp=%b%b", i, req0_ready, req1_ready, e0, e1);
      end
      if (req0_ready === 1'b1) n0++;
      if (req1_ready === 1'b1) n1++;
      cyc();
    end
    req1_valid = 1'b0;
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL cont_level got=%0d exp=8", fifo_level); end
  endtask

  task automatic test_full_pop();
    logic [9:0] exp_q [12];
    int got, p;
    logic r;
    exp_q[0] = 10'h001; exp_q[1] = 10'h101; exp_q[2]  = 10'h002; exp_q[3]  = 10'h102;
    exp_q[4] = 10'h003; exp_q[5] = 10'h103; exp_q[6]  = 10'h004; exp_q[7]  = 10'h104;
    exp_q[8] = 10'h201; exp_q[9] = 10'h202; exp_q[10] = 10'h203; exp_q[11] = 10'h204;
    en = 1'b1; div = 16'd0;
    req0_valid = 1'b1; req0_data = 10'h201;
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL full_ready_before got=%b exp=0", req0_ready); end
    cyc();
    total++; if (req0_ready !== 1'b1 || fifo_level !== 4'd7) begin bad++; $display("FAIL full_after_pop got=%b/%0d exp=1/7", req0_ready, fifo_level); end
    got = 0;
    if (update === 1'b1) begin
      total++;
      if (D !== exp_q[0]) begin bad++; $display("FAIL full_order0 got=%h exp=%h", D, exp_q[0]); end
      got = 1;
    end
    p = 0;
    for (int c = 0; c < 30; c++) begin
      req0_valid = (p < 4);
      req0_data  = 10'h201 + 10'(p);
      #1;
      r = req0_ready & req0_valid;
      cyc();
      if (r) p++;
      if (c < 4) begin
        total++; if (fifo_level !== 4'd7) begin bad++; $display("FAIL full_level%0d got=%0d exp=7", c, fifo_level); end
      end
      if (update === 1'b1) begin
        total++;
        if (got >= 12) begin
          bad++; $display("FAIL full_extra got=%h exp=none", D);
        end else if (D !== exp_q[got]) begin
          bad++; $display("FAIL full_order%0d got=%h exp=%h", got, D, exp_q[got]);
        end
        got++;
      end
    end
    req0_valid = 1'b0;
    total++; if (got !== 12) begin bad++; $display("FAIL full_count got=%0d exp=12", got); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL full_drained got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_underrun_clr();
    en = 1'b1; div = 16'd0; clr_underrun = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++; if (underrun !== 1'b1) begin bad++; $display("FAIL urun_race%0d got=%b exp=1", i, underrun); end
    end
    en = 1'b0;
    cyc();
    clr_underrun = 1'b0;
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL urun_clear got=%b exp=0", underrun); end
  endtask

  task automatic test_async_reset();
    logic [9:0] v [6];
    v[0] = 10'h2AA; v[1] = 10'h011; v[2] = 10'h012; v[3] = 10'h013; v[4] = 10'h014; v[5] = 10'h015;
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req0_data = v[i];
      #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL ares_push%0d got=%b exp=1", i, req0_ready); end
      cyc();
    end
    req0_valid = 1'b0;
    en = 1'b1; div = 16'd0;
    cyc();
    en = 1'b0;
    total++; if (D !== 10'h2AA || fifo_level !== 4'd5) begin bad++; $display("FAIL ares_pre got=%h/%0d exp=%h/5", D, fifo_level, 10'h2AA); end
    #2 reset = 1'b1;
    #1;
    total++; if (D !== 10'h000 || fifo_level !== 4'd0 || update !== 1'b0) begin
      bad++; $display("FAIL ares_immediate got=%h/%0d/%b exp=000/0/0", D, fifo_level, update);
    end
    #2 reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 10'h0C0; req1_data = 10'h0D0;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL ares_grant0 got=%b%b exp=10", req0_ready, req1_ready); end
    cyc();
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL ares_grant1 got=%b%b exp=01", req0_ready, req1_ready); end
    total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL ares_level got=%0d exp=1", fifo_level); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_pacing();
    test_no_bypass();
    test_contention();
    test_full_pop();
    test_underrun_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
